// File: rtl/reg_writeback_if.sv
// reg_writeback_if: result-offer channel from the ALU/load unit into the writeback queue.
interface reg_writeback_if #(parameter int WIDTH = 16);
  logic             res_valid;
  logic [3:0]       res_reg;
  logic [WIDTH-1:0] res_data;
  logic             res_ready;
  modport master (output res_valid, res_reg, res_data, input res_ready);
  modport slave  (input res_valid, res_reg, res_data, output res_ready);
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: queues results for the register bank, issues PC updates with priority,
// and forwards queued/in-flight writes to operand reads.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  reg_writeback_if.slave   res,
  input  logic             pc_valid,
  input  logic [WIDTH-1:0] pc_value,
  input  logic             flush,
  input  logic [3:0]       src_reg,
  input  logic [3:0]       dst_reg,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_fwd,
  output logic [WIDTH-1:0] b_fwd,
  output logic             wr_en,
  output logic [3:0]       wr_reg,
  output logic [WIDTH-1:0] wr_data,
  output logic             pc_inc,
  output logic [WIDTH-1:0] pc_data_in,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, PCUPD} state_t;
  state_t state, state_n;
  logic [3:0]       mem_reg  [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pc_pend;
  logic             pc_pend_v;
  logic             push_acc, q_issue, pop, store;
  logic [3:0]       head_reg;
  logic [WIDTH-1:0] head_data;
  assign res.res_ready = count != CW'(DEPTH);
  assign busy          = (count != '0) | pc_pend_v;
  assign wr_en         = state == DRAIN;
  assign pc_inc        = state == PCUPD;
  // res_reg 0 is accepted but never stored: the PC is only written via the pc port
  assign push_acc  = res.res_valid & res.res_ready & ~flush & (res.res_reg != 4'd0);
  // An empty queue hands the arriving result straight to the write port for one-cycle latency
  assign head_reg  = count != '0 ? mem_reg[rd_ptr]  : res.res_reg;
  assign head_data = count != '0 ? mem_data[rd_ptr] : res.res_data;
  // A PC arriving this edge holds off both queue issue and an older PC so the latest value wins
  assign q_issue = ~pc_pend_v & ~pc_valid & ~flush & ((count != '0) | push_acc);
  assign pop     = q_issue & (count != '0);
  assign store   = push_acc & ~(q_issue & (count == '0));
  always_comb begin
    state_n = IDLE;
    state_n = (pc_pend_v & ~pc_valid) ? PCUPD : q_issue ? DRAIN : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pc_pend    <= '0;
      pc_pend_v  <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
      pc_data_in <= '0;
    end else begin
      rd_ptr    <= rd_ptr + AW'(pop);
      wr_ptr    <= flush ? rd_ptr : wr_ptr + AW'(store);
      count     <= flush ? '0 : count + CW'(store) - CW'(pop);
      pc_pend   <= pc_valid ? pc_value : pc_pend;
      pc_pend_v <= pc_valid | (pc_pend_v & (state_n != PCUPD));
      if (state_n == PCUPD) pc_data_in <= pc_pend;
      if (q_issue) begin
        wr_reg  <= head_reg;
        wr_data <= head_data;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (store) begin
      mem_reg[wr_ptr]  <= res.res_reg;
      mem_data[wr_ptr] <= res.res_data;
    end
  end
  // Oldest-to-newest scan so the newest matching entry overrides older ones and the write port
  function automatic logic [WIDTH-1:0] fwd(input logic [3:0] r, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] f;
    logic [AW-1:0]    idx;
    f = (wr_en && wr_reg == r) ? wr_data : v;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (CW'(i) < count && mem_reg[idx] == r) f = mem_data[idx];
    end
    return r == 4'd0 ? (pc_pend_v ? pc_pend : v) : f;
  endfunction
  always_comb begin
    a_fwd = fwd(src_reg, a_in);
    b_fwd = fwd(dst_reg, b_in);
  end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed self-checking bench for reg_writeback (DEPTH 4, WIDTH 16).
module tb_reg_writeback;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_valid, flush;
  logic [15:0] pc_value, a_in, b_in;
  logic [3:0]  src_reg, dst_reg;
  logic [15:0] a_fwd, b_fwd, wr_data, pc_data_in;
  logic [3:0]  wr_reg;
  logic        wr_en, pc_inc, busy;
  int checks = 0;
  int errors = 0;
  reg_writeback_if #(.WIDTH(16)) rif();
  reg_writeback #(.DEPTH(4), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .res(rif), .pc_valid(pc_valid), .pc_value(pc_value),
    .flush(flush), .src_reg(src_reg), .dst_reg(dst_reg), .a_in(a_in), .b_in(b_in),
    .a_fwd(a_fwd), .b_fwd(b_fwd), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .pc_inc(pc_inc), .pc_data_in(pc_data_in), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic v, input logic [3:0] r, input logic [15:0] d);
    rif.res_valid = v;
    rif.res_reg   = r;
    rif.res_data  = d;
  endtask
  initial begin
    offer(1'b0, 4'd0, 16'h0);
    pc_valid = 0; pc_value = 0; flush = 0;
    src_reg = 0; dst_reg = 0; a_in = 16'hAAAA; b_in = 16'hBBBB;
    #3;
    chk("rst_wr_en", 16'(wr_en), 16'd0);
    chk("rst_pc_inc", 16'(pc_inc), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_wr_data", wr_data, 16'h0);
    chk("rst_pc_data", pc_data_in, 16'h0);
    chk("rst_a_fwd", a_fwd, 16'hAAAA);
    step(); step();
    rst = 1;
    chk("rel_ready", 16'(rif.res_ready), 16'd1);
    // single result, one-cycle latency
    offer(1'b1, 4'd4, 16'h0014);
    step();
    chk("lat_wr_en", 16'(wr_en), 16'd1);
    chk("lat_wr_reg", 16'(wr_reg), 16'd4);
    chk("lat_wr_data", wr_data, 16'h0014);
    offer(1'b0, 4'd0, 16'h0);
    step();
    chk("lat_wr_en_off", 16'(wr_en), 16'd0);
    chk("lat_busy_off", 16'(busy), 16'd0);
    chk("idle_hold_data", wr_data, 16'h0014);
    // r0 result is accepted and dropped
    offer(1'b1, 4'd0, 16'hDEAD);
    chk("r0_ready", 16'(rif.res_ready), 16'd1);
    step();
    offer(1'b0, 4'd0, 16'h0);
    step();
    chk("r0_no_wr", 16'(wr_en), 16'd0);
    chk("r0_busy", 16'(busy), 16'd0);
    // back-to-back PC values: only the latest issues, once
    pc_valid = 1; pc_value = 16'h0010;
    step();
    chk("pc1_no_inc", 16'(pc_inc), 16'd0);
    chk("pc1_busy", 16'(busy), 16'd1);
    chk("pc1_fwd_r0", a_fwd, 16'h0010);
    pc_value = 16'h0012;
    step();
    chk("pc2_no_inc", 16'(pc_inc), 16'd0);
    pc_valid = 0;
    step();
    chk("pc_inc_on", 16'(pc_inc), 16'd1);
    chk("pc_inc_val", pc_data_in, 16'h0012);
    chk("pc_busy_off", 16'(busy), 16'd0);
    chk("pc_fwd_r0_off", a_fwd, 16'hAAAA);
    step();
    chk("pc_inc_single", 16'(pc_inc), 16'd0);
    chk("pc_data_hold", pc_data_in, 16'h0012);
    // fill under a held PC, then PC issues first, then in-order drain with forwarding
    src_reg = 5; a_in = 16'h1111; dst_reg = 6; b_in = 16'h2222;
    pc_valid = 1; pc_value = 16'h0040;
    offer(1'b1, 4'd5, 16'h000F);
    step();
    chk("fwd_one_r5", a_fwd, 16'h000F);
    offer(1'b1, 4'd5, 16'h0022);
    step();
    chk("fwd_newest_r5", a_fwd, 16'h0022);
    offer(1'b1, 4'd6, 16'h0066);
    step();
    offer(1'b1, 4'd7, 16'h0077);
    step();
    chk("full_ready", 16'(rif.res_ready), 16'd0);
    chk("full_no_wr", 16'(wr_en), 16'd0);
    chk("full_fwd_b", b_fwd, 16'h0066);
    pc_valid = 0;
    offer(1'b1, 4'd8, 16'h0088);
    step();
    offer(1'b0, 4'd0, 16'h0);
    chk("full_pc_first", 16'(pc_inc), 16'd1);
    chk("full_pc_val", pc_data_in, 16'h0040);
    chk("full_pc_no_wr", 16'(wr_en), 16'd0);
    chk("full_still", 16'(rif.res_ready), 16'd0);
    step();
    chk("d1_wr_en", 16'(wr_en), 16'd1);
    chk("d1_pc_inc", 16'(pc_inc), 16'd0);
    chk("d1_reg", 16'(wr_reg), 16'd5);
    chk("d1_data", wr_data, 16'h000F);
    chk("d1_fwd_a", a_fwd, 16'h0022);
    chk("d1_ready", 16'(rif.res_ready), 16'd1);
    step();
    chk("d2_reg", 16'(wr_reg), 16'd5);
    chk("d2_data", wr_data, 16'h0022);
    chk("d2_fwd_inflight", a_fwd, 16'h0022);
    step();
    chk("d3_reg", 16'(wr_reg), 16'd6);
    chk("d3_data", wr_data, 16'h0066);
    chk("d3_fwd_b", b_fwd, 16'h0066);
    chk("d3_fwd_a_pass", a_fwd, 16'h1111);
    step();
    chk("d4_wr_en", 16'(wr_en), 16'd1);
    chk("d4_reg", 16'(wr_reg), 16'd7);
    chk("d4_data", wr_data, 16'h0077);
    step();
    chk("d5_wr_en", 16'(wr_en), 16'd0);
    chk("d5_busy", 16'(busy), 16'd0);
    chk("d5_fwd_b_pass", b_fwd, 16'h2222);
    // flush with a concurrent offer
    pc_valid = 1; pc_value = 16'h0050;
    offer(1'b1, 4'd1, 16'h0001); step();
    offer(1'b1, 4'd2, 16'h0002); step();
    offer(1'b1, 4'd3, 16'h0003); step();
    chk("fl_busy_pre", 16'(busy), 16'd1);
    pc_valid = 0; flush = 1;
    offer(1'b1, 4'd9, 16'h0099);
    step();
    flush = 0;
    offer(1'b0, 4'd0, 16'h0);
    chk("fl_pc_kept", pc_data_in, 16'h0050);
    chk("fl_busy", 16'(busy), 16'd0);
    chk("fl_ready", 16'(rif.res_ready), 16'd1);
    step();
    chk("fl_no_wr1", 16'(wr_en), 16'd0);
    step();
    chk("fl_no_wr2", 16'(wr_en), 16'd0);
    // asynchronous reset in the middle of a drain
    pc_valid = 1; pc_value = 16'h0060;
    offer(1'b1, 4'd10, 16'h00A0); step();
    offer(1'b1, 4'd11, 16'h00B1); step();
    offer(1'b1, 4'd12, 16'h00C2); step();
    pc_valid = 0;
    offer(1'b0, 4'd0, 16'h0);
    step();
    step();
    chk("ar_wr_en", 16'(wr_en), 16'd1);
    chk("ar_reg", 16'(wr_reg), 16'd10);
    #2;
    rst = 0;
    #1;
    chk("ar_async_wr_en", 16'(wr_en), 16'd0);
    chk("ar_async_busy", 16'(busy), 16'd0);
    chk("ar_async_reg", 16'(wr_reg), 16'd0);
    step();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_post_wr_en", 16'(wr_en), 16'd0);
      chk("ar_post_ready", 16'(rif.res_ready), 16'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DEPTH, default 4, write-queue entries (power of two, 2..8).
REQ-002 Parameter WIDTH, default 16, datapath width.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; state cleared while rst=0.
REQ-005 res_valid  input  1  ALU/load result offered.
REQ-006 res_reg  input  4  destination register of offered result.
REQ-007 res_data  input  WIDTH  offered result value.
REQ-008 res_ready  output  1  queue can accept; equals not-full.
REQ-009 pc_valid  input  1  new PC value offered (always accepted).
REQ-010 pc_value  input  WIDTH  new PC value.
REQ-011 flush  input  1  discard all queued, not-yet-issued results.
REQ-012 src_reg, dst_reg  input  4 each  operand register numbers presented to the register bank.
REQ-013 a_in, b_in  input  WIDTH each  operand values returned by the register bank.
REQ-014 a_fwd, b_fwd  output  WIDTH each  operand values with queued writes forwarded.
REQ-015 wr_en, wr_reg, wr_data  output  1/4/WIDTH  register-bank write port, registered.
REQ-016 pc_inc, pc_data_in  output  1/WIDTH  register-bank PC update port, registered.
REQ-017 busy  output  1  queue non-empty or PC update pending.

Function
REQ-018 Push: res_valid=1 and res_ready=1 at an edge writes {res_reg,res_data} at tail; no push when full, even if a pop occurs same edge.
REQ-019 res_reg=0 entries shall be dropped at push (PC only via pc port); res_ready still honoured.
REQ-020 pc_valid=1 at an edge loads pc_pend and sets pc_pend_v; a second pc_valid before issue overwrites value (latest wins).
REQ-021 FSM states IDLE, DRAIN, PCUPD; state register updated every edge.
REQ-022 Next-state: pc_pend_v -> PCUPD; else queue non-empty -> DRAIN; else IDLE. PC has priority over queue.
REQ-023 PCUPD: outputs pc_inc=1, pc_data_in=pc_pend, wr_en=0 for exactly one cycle; pc_pend_v cleared at that edge unless pc_valid same edge.
REQ-024 DRAIN: outputs wr_en=1, wr_reg/wr_data = head entry for one cycle; head popped at that edge.
REQ-025 wr_en and pc_inc shall never be 1 in the same cycle.
REQ-026 IDLE: wr_en=0, pc_inc=0; wr_reg, wr_data, pc_data_in hold previous values.
REQ-027 Latency: result pushed at edge N with empty queue, no PC pending -> wr_en=1 during cycle N+1.
REQ-028 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, 0..DEPTH.
REQ-029 Forwarding: a_fwd = data of newest valid queue entry with reg == src_reg, else entry being written (wr_en=1, wr_reg==src_reg), else a_in; b_fwd likewise with dst_reg; purely combinational.
REQ-030 src_reg=0 or dst_reg=0 shall forward pc_pend if pc_pend_v, else pass a_in/b_in.
REQ-031 flush=1 at an edge empties queue (count=0, pointers equal) and cancels any push that edge; pc_pend and the current output cycle are unaffected.
REQ-032 busy = (count!=0) or pc_pend_v.

Reset
REQ-033 rst=0 asynchronously: state=IDLE, count=0, pointers=0, pc_pend_v=0, pc_pend=0, wr_en=0, wr_reg=0, wr_data=0, pc_inc=0, pc_data_in=0; res_ready=1 after release.
REQ-034 Reset mid-DRAIN or mid-PCUPD aborts the output cycle immediately; queued entries are lost.

Verification
REQ-035 Push r4=0x0014 into empty queue -> next cycle wr_en=1, wr_reg=4, wr_data=0x0014; following cycle wr_en=0, busy=0.
REQ-036 Push 4 entries back-to-back while pc_valid held each cycle -> queue fills, res_ready=0 on 5th, pc_inc pulses first; writes then issue in order, no loss, wr_en/pc_inc never coincident.
REQ-037 Queue holds r5=0x000F then r5=0x0022; src_reg=5, a_in=0x1111 -> a_fwd=0x0022; after both drain a_fwd=a_in.
REQ-038 pc_valid 0x0010 then 0x0012 on consecutive edges before issue -> single pc_inc with pc_data_in=0x0012.
REQ-039 3 entries queued, flush with res_valid same edge -> count=0, busy=0, no wr_en afterwards.
REQ-040 rst low during DRAIN with 2 entries queued -> wr_en falls without clock edge; after release no writes issue, res_ready=1.
